// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: PC advance/hold/redirect decisions,
// IF/ID and ID/EX write/flush controls, boot hold and a saturating stall counter.
module fetch_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned LU_BUBBLES  = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jr,
  output logic             Z_o,
  output logic             J_o,
  output logic             JR_o,
  output logic             PC_IFWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StBoot, StRun, StStall, StWait} state_e;

  localparam logic [3:0] BootInit   = 4'(BOOT_CYCLES);
  localparam logic [1:0] BubbleInit = 2'(LU_BUBBLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic [1:0]       bubble_q, bubble_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    bubble_d   = bubble_q;
    Z_o        = 1'b0;
    J_o        = 1'b0;
    JR_o       = 1'b0;
    PC_IFWrite = 1'b0;
    IFID_Write = 1'b0;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;

    if (state_q == StBoot) begin
      // Event inputs are ignored until the boot hold has elapsed.
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      boot_cnt_d = boot_cnt_q - 4'd1;
      if (boot_cnt_q <= 4'd1) state_d = StRun;
    end else if (branch_taken) begin
      Z_o        = 1'b1;
      PC_IFWrite = 1'b1;
      IFID_Write = 1'b1;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      state_d    = StRun;
    end else if (load_use || state_q == StStall) begin
      IDEX_Flush = 1'b1;
      if (state_q == StStall) begin
        bubble_d = bubble_q - 2'd1;
        state_d  = (bubble_q <= 2'd1) ? StRun : StStall;
      end else begin
        bubble_d = BubbleInit;
        state_d  = (BubbleInit == 2'd0) ? StRun : StStall;
      end
    end else if (jr || jump) begin
      // jr outranks jump so the redirect selects stay one-hot.
      JR_o       = jr;
      J_o        = ~jr;
      PC_IFWrite = 1'b1;
      IFID_Write = 1'b1;
      IFID_Flush = 1'b1;
      state_d    = StRun;
    end else if (!imem_ready) begin
      IFID_Write = 1'b1;
      IFID_Flush = 1'b1;
      state_d    = StWait;
    end else begin
      PC_IFWrite = 1'b1;
      IFID_Write = 1'b1;
      state_d    = StRun;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != StBoot && !PC_IFWrite && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StBoot;
      boot_cnt_q  <= BootInit;
      bubble_q    <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      bubble_q    <= bubble_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage.
- Decides each cycle whether the PC advances, holds, or redirects, and generates the one-hot redirect selects (Z/J/JR) and the PC_IFWrite enable consumed by IF.
- Drives IF/ID and ID/EX pipeline-register write/flush controls.
- Handles post-reset boot hold, load-use stalls, multi-cycle instruction-memory waits and branch/jump squashes; counts stall cycles for performance debug.

Parameters:
- BOOT_CYCLES, 2, cycles PC is held after reset release before the first fetch advances (1..15).
- LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_ready  input  1  instruction memory has valid data for current PC.
- load_use  input  1  ID-stage load-use hazard detected.
- branch_taken  input  1  EX-stage branch resolved taken.
- jump  input  1  ID-stage J-type jump.
- jr  input  1  ID-stage jump-register.
- Z_o  output  1  branch select to IF.
- J_o  output  1  jump select to IF.
- JR_o  output  1  jump-register select to IF.
- PC_IFWrite  output  1  PC update enable to IF.
- IFID_Write  output  1  IF/ID register write enable.
- IFID_Flush  output  1  IF/ID register load bubble.
- IDEX_Flush  output  1  ID/EX register load bubble.
- stall_cnt  output  CNT_W  saturating count of cycles with PC_IFWrite=0 outside BOOT.

Behaviour:
- States: BOOT, RUN, STALL, WAIT. Registered: state, boot counter, bubble counter, stall_cnt. All other outputs are combinational from state and inputs.
- Reset (reset=0, asynchronous): state=BOOT, boot counter=BOOT_CYCLES, stall_cnt=0. Resulting outputs: PC_IFWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, Z_o=J_o=JR_o=0.
- BOOT: outputs as in reset; all event inputs ignored; counter decrements each cycle. At 0 -> RUN, so the first PC advance happens in cycle BOOT_CYCLES+1 after reset release.
- RUN/STALL/WAIT event priority, first match wins:
  1. branch_taken: Z_o=1, PC_IFWrite=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=1; next=RUN. Aborts any stall or wait.
  2. load_use, or state=STALL: PC_IFWrite=0, IFID_Write=0, IDEX_Flush=1. Entering from RUN/WAIT loads bubble counter=LU_BUBBLES-1. If that value is 0 -> RUN, else -> STALL. In STALL, decrement; at 0 -> RUN.
  3. jr: JR_o=1, PC_IFWrite=1, IFID_Write=1, IFID_Flush=1; next=RUN.
  4. jump: J_o=1, same controls as jr; next=RUN.
  5. !imem_ready: PC_IFWrite=0, IFID_Write=1, IFID_Flush=1 (bubble into ID); next=WAIT.
  6. Otherwise: PC_IFWrite=1, IFID_Write=1, no flush; next=RUN.
- Redirects write the PC regardless of imem_ready; the outstanding fetch is abandoned.
- Z_o/J_o/JR_o are one-hot or all zero. Simultaneous jump and jr: JR_o only.
- stall_cnt increments on every non-BOOT cycle with PC_IFWrite=0 and saturates at all-ones (no wrap). Cleared only by reset.
- Reset mid-STALL/WAIT: immediate return to BOOT; counters reloaded.

Test Plan:
- Release reset with BOOT_CYCLES=2, imem_ready=1 -> PC_IFWrite=0 for 2 cycles, 1 from cycle 3; IFID_Flush=1 during BOOT; stall_cnt stays 0.
- load_use pulse 1 cycle, LU_BUBBLES=2 -> PC_IFWrite=0 and IDEX_Flush=1 for exactly 2 cycles, then RUN; stall_cnt=2.
- imem_ready low 3 cycles -> PC_IFWrite=0, IFID_Flush=1 for 3 cycles; advance on 4th; stall_cnt +3.
- branch_taken together with load_use, jr and imem_ready=0 -> Z_o=1 only, PC_IFWrite=1, both flushes=1, next state RUN; branch_taken in 2nd STALL cycle exits the stall.
- jump and jr together -> JR_o=1, J_o=0, IFID_Flush=1, IDEX_Flush=0. jump with load_use -> stall, J_o=0.
- CNT_W=4, hold load_use 20 cycles -> stall_cnt saturates at 15; async reset mid-WAIT -> all outputs at reset values immediately, before the next clk edge.
